if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the five-stage CPU; the reader side of the instruction ROM.
//  Owns the PC, drives the ROM address, and captures the returned 21-bit word into the IF/ID register.
//  Services ID-stage stall and EX-stage branch/jump redirect; feeds the decode stage.
// PARAMETERS
//  ADDR_W    8                 PC / ROM address width
//  INS_W     21                instruction width
//  RESET_PC  8'd0              PC value loaded on reset
//  NOP_WORD  21'h140000        bubble word (opcode 4'b1010, all fields 0)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  stall          in   1       hold PC and IF/ID (load-use hazard from ID)
//  redirect_en    in   1       taken branch/jump resolved in EX
//  redirect_addr  in   ADDR_W  new PC when redirect_en=1
//  ins_addr       out  ADDR_W  ROM address (= current PC, combinational)
//  ins_data       in   INS_W   ROM read data (combinational ROM, same cycle)
//  if_pc          out  ADDR_W  PC of the instruction held in IF/ID
//  if_ins         out  INS_W   instruction held in IF/ID
//  if_valid       out  1       IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  - Reset (async, rst=1): pc=RESET_PC; if_ins=NOP_WORD; if_pc=0; if_valid=0. Holds while rst is high.
//  - ins_addr is driven directly from the pc register; there is no pipeline on the address path.
//  - Per rising edge, priority order:
//    1. redirect_en: pc<=redirect_addr; if_ins<=NOP_WORD; if_valid<=0 (flush). Overrides stall.
//    2. stall:       pc, if_ins, if_pc, if_valid all hold.
//    3. normal:      if_ins<=ins_data; if_pc<=pc; if_valid<=1; pc<=next_seq.
//  - next_seq = pc+1, modulo 2^ADDR_W (8'hFF -> 8'h00 wraps with no error flag).
//  - Latency: an instruction at address A appears on if_ins one cycle after pc==A with no stall.
//  - First valid IF/ID: one edge after rst deasserts (word at RESET_PC).
//  - Redirect target fetched the cycle after redirect; exactly one bubble per redirect.
//  - redirect_en and stall asserted together: redirect wins, and the stall is dropped for that cycle.
//  - Reset mid-stream: IF/ID returns to a bubble at once; no partial state is kept.
//  - Opcode field is ins[20:17]; 8-bit immediate is ins[7:0].
// CONFIGURATION
//  FETCH_EARLY_JMP_EN defined:
//  - If ins_data[20:17]==4'b1001 (JMP) in a normal cycle, pc<=ins_data[7:0] instead of pc+1.
//  - The JMP is still latched into IF/ID with if_valid=1. Zero-bubble unconditional jump.
//  - EX must not redirect again for a JMP whose if_ins[20:17] was pre-taken.
//  - redirect_en and stall keep priority over the early jump.
//  FETCH_EARLY_JMP_EN undefined:
//  - Strictly sequential fetch; JMP is resolved only by redirect_en (one bubble).
// STRUCTURE
//  - cpu_isa_pkg (shared): ADDR_W, INS_W, NOP_WORD, opcode constants (OPC_JMP=4'b1001, OPC_BR=4'b1000, OPC_NOP=4'b1010).
//  - Field-slice macros/functions for opcode and imm8 also live in cpu_isa_pkg.
//  - One sub-module: if_id_reg (enable + synchronous flush-to-NOP + async reset).
//  - PC logic and next-PC mux stay in if_fetch_unit.
// TESTING
//  1. Reset, ROM[0..3]=distinct words, no stall
//     -> ins_addr 0,1,2,3 on successive cycles; if_ins follows one cycle later; if_valid=1 from first edge.
//  2. stall=1 for 3 cycles at pc=5
//     -> ins_addr stays 5; if_ins and if_pc unchanged; fetch resumes at 5 -> 6 after release.
//  3. redirect_en=1, redirect_addr=8'h0B, at pc=12
//     -> next ins_addr=11; one cycle if_ins=NOP_WORD with if_valid=0; ROM[11] then latched.
//  4. stall=1 and redirect_en=1 together (addr 8'h20)
//     -> pc=8'h20 next cycle and IF/ID flushed; stall ignored.
//  5. pc=8'hFF, no stall -> next ins_addr=8'h00; if_pc=8'hFF with ROM[255].
//     Separately: rst pulsed mid-run -> outputs return to reset values asynchronously.
//  6. FETCH_EARLY_JMP_EN: ROM[15]=JMP imm 8'h0B -> ins_addr 15 then 11, no bubble.
//     Without the macro: ins_addr 15 then 16.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the five-stage CPU: datapath widths, the bubble word,
// opcode constants and field-slice helpers used by the fetch and decode stages.
//
// Instruction word layout (21 bits):
//   [20:17] opcode
//   [16:8]  register / misc fields (decoded in ID)
//   [7:0]   8-bit immediate / jump target
package cpu_isa_pkg;

  // Datapath widths
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INS_W  = 21;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned IMM8_W = 8;

  // Field positions
  localparam int unsigned OPC_MSB = 20;
  localparam int unsigned OPC_LSB = 17;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_BR  = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_NOP = 4'b1010;

  // Bubble word: NOP opcode with every other field zero
  localparam logic [INS_W-1:0] NOP_WORD = {OPC_NOP, {(INS_W - OPC_W){1'b0}}};

  // Opcode field of an instruction word
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INS_W-1:0] ins);
    return ins[OPC_MSB:OPC_LSB];
  endfunction

  // 8-bit immediate field of an instruction word
  function automatic logic [IMM8_W-1:0] imm8_of(input logic [INS_W-1:0] ins);
    return ins[IMM8_W-1:0];
  endfunction

  // True for an unconditional jump
  function automatic logic is_jmp(input logic [INS_W-1:0] ins);
    return opcode_of(ins) == OPC_JMP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched word, its PC and a valid flag.
// Flush has priority over enable and loads a bubble; asynchronous active-high reset
// also loads a bubble so decode never sees stale state after reset.
module if_id_reg
  import cpu_isa_pkg::*;
#(
  parameter int unsigned       AddrW   = 8,
  parameter int unsigned       InsW    = 21,
  parameter logic [InsW-1:0]   NopWord = 21'h140000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [AddrW-1:0] pc_i,
  input  logic [InsW-1:0]  ins_i,
  output logic [AddrW-1:0] pc_o,
  output logic [InsW-1:0]  ins_o,
  output logic             valid_o
);

  logic [AddrW-1:0] pc_q, pc_d;
  logic [InsW-1:0]  ins_q, ins_d;
  logic             valid_q, valid_d;

  // Next-state select: flush beats load, load beats hold
  always_comb begin
    pc_d    = pc_q;
    ins_d   = ins_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      ins_d   = NopWord;
      valid_d = 1'b0;
    end else if (en_i) begin
      pc_d    = pc_i;
      ins_d   = ins_i;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      ins_q   <= NopWord;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign ins_o   = ins_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM and
// captures the returned word into the IF/ID register.
//
// Next-PC priority per edge: EX redirect (flushes IF/ID, overrides stall), then ID stall
// (everything holds), then normal sequential fetch with 2^ADDR_W wrap-around.
//
// Optional feature, macro FETCH_EARLY_JMP_EN: a JMP seen on ins_data in a normal cycle
// steers the PC straight to its imm8 target, so unconditional jumps cost no bubble. The
// JMP itself still enters IF/ID as a valid instruction; EX must not redirect for it again.
// With the macro undefined fetch is strictly sequential and JMP resolves via redirect_en.
module if_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int unsigned        ADDR_W   = cpu_isa_pkg::ADDR_W,
  parameter int unsigned        INS_W    = cpu_isa_pkg::INS_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INS_W-1:0]   NOP_WORD = cpu_isa_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic [INS_W-1:0]  ins_data,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INS_W-1:0]  if_ins,
  output logic              if_valid
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_seq;
  logic              jmp_take;
  logic              ifid_en;
  logic              ifid_flush;

  // Early-jump detect; tied off when the feature is not built
  always_comb begin
    jmp_take = 1'b0;
`ifdef FETCH_EARLY_JMP_EN
    jmp_take = is_jmp(ins_data);
`endif
  end

  // Next-PC mux: redirect > stall > early jump > sequential (wraps silently)
  always_comb begin
    pc_seq = pc_q + ADDR_W'(1);
    if (redirect_en) begin
      pc_d = redirect_addr;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (jmp_take) begin
      pc_d = ADDR_W'(imm8_of(ins_data));
    end else begin
      pc_d = pc_seq;
    end
  end

  // PC register, loads RESET_PC asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // ROM address comes straight from the PC, no extra pipeline stage
  assign ins_addr = pc_q;

  // A redirect drops any concurrent stall, so flush is evaluated ahead of enable
  assign ifid_flush = redirect_en;
  assign ifid_en    = ~stall;

  if_id_reg #(
    .AddrW   (ADDR_W),
    .InsW    (INS_W),
    .NopWord (NOP_WORD)
  ) u_if_id_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (ifid_en),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .ins_i   (ins_data),
    .pc_o    (if_pc),
    .ins_o   (if_ins),
    .valid_o (if_valid)
  );

endmodule
